// File: rtl/data_distributor_pkg.sv
// rtl/data_distributor_pkg.sv - shared helpers for the one-hot selector/distributor pair
package data_distributor_pkg;

    localparam int MAX_SEL_WIDTH    = 64;
    localparam int DROP_COUNT_WIDTH = 8;
    localparam logic [DROP_COUNT_WIDTH-1:0] DROP_MAX = '1;

    // Callers zero-extend their select to MAX_SEL_WIDTH; extension preserves one-hotness.
    function automatic logic is_onehot(input logic [MAX_SEL_WIDTH-1:0] sel);
        return $onehot(sel);
    endfunction

endpackage

// File: rtl/data_distributor_lane.sv
// rtl/data_distributor_lane.sv - one-entry registered buffer for one output lane
module data_distributor_lane #(
    parameter int DATA_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_ready,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  can_take
);

    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_data;

    // A full lane may refill in the same cycle its consumer drains it.
    assign can_take = !r_valid || rd_ready;
    assign rd_valid = r_valid;
    assign rd_data  = r_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (wr_en) begin
            r_valid <= 1'b1;
            r_data  <= wr_data;
        end else if (r_valid && rd_ready) begin
            r_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/data_distributor.sv
// rtl/data_distributor.sv - one-hot demux of one producer onto independently backpressured lanes
module data_distributor
    import data_distributor_pkg::*;
#(
    parameter int SEL_WIDTH  = 5,
    parameter int DATA_WIDTH = 5
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic [SEL_WIDTH-1:0]        sel_in,
    input  logic [DATA_WIDTH-1:0]       data_in,
    input  logic                        data_in_valid,
    output logic                        data_in_ready,
    output logic [DATA_WIDTH-1:0]       data_out [0:SEL_WIDTH-1],
    output logic [SEL_WIDTH-1:0]        data_out_valid,
    input  logic [SEL_WIDTH-1:0]        data_out_ready,
    output logic                        sel_error,
    output logic [DROP_COUNT_WIDTH-1:0] drop_count
);

    logic [SEL_WIDTH-1:0]        w_can_take;
    logic [SEL_WIDTH-1:0]        w_wr_en;
    logic                        w_legal;
    logic                        w_xfer;
    logic                        r_sel_error;
    logic [DROP_COUNT_WIDTH-1:0] r_drop_count;

    assign w_legal = is_onehot(MAX_SEL_WIDTH'(sel_in));

    // Illegal selects are always taken so a bad producer cannot stall itself.
    assign data_in_ready = !flush && (!w_legal || |(sel_in & w_can_take));
    assign w_xfer        = data_in_valid && data_in_ready;
    assign w_wr_en       = (w_xfer && w_legal) ? sel_in : '0;

    for (genvar i = 0; i < SEL_WIDTH; i++) begin : g_lane
        data_distributor_lane #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .flush    (flush),
            .wr_en    (w_wr_en[i]),
            .wr_data  (data_in),
            .rd_ready (data_out_ready[i]),
            .rd_valid (data_out_valid[i]),
            .rd_data  (data_out[i]),
            .can_take (w_can_take[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sel_error  <= 1'b0;
            r_drop_count <= '0;
        end else begin
            r_sel_error <= w_xfer && !w_legal;
            if (w_xfer && !w_legal && r_drop_count != DROP_MAX) begin
                r_drop_count <= r_drop_count + 1'b1;
            end
        end
    end

    assign sel_error  = r_sel_error;
    assign drop_count = r_drop_count;

endmodule

// File: tb/tb_data_distributor.sv
// tb/tb_data_distributor.sv - randomized and directed self-checking bench for data_distributor
module tb_data_distributor;

    localparam int SW = 5;
    localparam int DW = 5;

    logic          clk;
    logic          rst;
    logic          flush;
    logic [SW-1:0] sel_in;
    logic [DW-1:0] data_in;
    logic          data_in_valid;
    logic          data_in_ready;
    logic [DW-1:0] data_out [0:SW-1];
    logic [SW-1:0] data_out_valid;
    logic [SW-1:0] data_out_ready;
    logic          sel_error;
    logic [7:0]    drop_count;

    int n_cmp;
    int n_fail;

    // Reference model: each lane is a depth-1 FIFO plus a "last word written" value.
    bit            m_full [SW];
    logic [DW-1:0] m_word [SW];
    int            m_drops;
    bit            m_sel_err;
    bit            exp_ready;
    logic          obs_ready;

    data_distributor #(
        .SEL_WIDTH  (SW),
        .DATA_WIDTH (DW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .sel_in         (sel_in),
        .data_in        (data_in),
        .data_in_valid  (data_in_valid),
        .data_in_ready  (data_in_ready),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .data_out_ready (data_out_ready),
        .sel_error      (sel_error),
        .drop_count     (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic m_reset();
        for (int i = 0; i < SW; i++) begin
            m_full[i] = 0;
            m_word[i] = '0;
        end
        m_drops   = 0;
        m_sel_err = 0;
    endtask

    function automatic logic [SW-1:0] m_valid_vec();
        logic [SW-1:0] v;
        for (int i = 0; i < SW; i++) v[i] = m_full[i];
        return v;
    endfunction

    // Drive one cycle (called at posedge+1), record observed ready, advance the model.
    task automatic do_cycle(input bit f, input logic [SW-1:0] s, input logic [DW-1:0] d,
                            input bit v, input logic [SW-1:0] r);
        bit legal;
        bit xfer;
        bit lane_ok;
        flush = f; sel_in = s; data_in = d; data_in_valid = v; data_out_ready = r;
        #1;
        legal   = $onehot(s);
        lane_ok = 0;
        for (int i = 0; i < SW; i++)
            if (s[i] && (!m_full[i] || r[i])) lane_ok = 1;
        exp_ready = !f && (!legal || lane_ok);
        obs_ready = data_in_ready;
        xfer      = v && exp_ready;
        @(posedge clk);
        for (int i = 0; i < SW; i++) begin
            if (f) m_full[i] = 0;
            else if (xfer && legal && s[i]) begin
                m_full[i] = 1;
                m_word[i] = d;
            end else if (m_full[i] && r[i]) m_full[i] = 0;
        end
        m_sel_err = xfer && !legal;
        if (xfer && !legal && m_drops < 255) m_drops++;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; sel_in = '0; data_in = '0;
        data_in_valid = 1'b0; data_out_ready = '0;
        m_reset();
        #2;
        for (int k = 0; k < 4; k++) begin
            sel_in = (k == 3) ? 5'b00000 : (5'b00001 << (k * 2));
            #1;
            n_cmp++;
            if (data_in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_ready sel=%b got %b want 1", sel_in, data_in_ready);
            end
        end
        flush = 1'b1; #1;
        n_cmp++;
        if (data_in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flush_ready got %b want 0", data_in_ready);
        end
        flush = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (data_out_valid !== '0 || sel_error !== 1'b0 || drop_count !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_state valid=%b err=%b drops=%0d want 0/0/0",
                     data_out_valid, sel_error, drop_count);
        end
        for (int i = 0; i < SW; i++) begin
            n_cmp++;
            if (data_out[i] !== '0) begin
                n_fail++;
                $display("FAIL reset_data lane%0d got %h want 0", i, data_out[i]);
            end
        end
    endtask

    task automatic test_single_lane();
        do_cycle(0, 5'b00100, 5'h15, 1, 5'b00000);
        n_cmp++;
        if (obs_ready !== 1'b1) begin
            n_fail++; $display("FAIL lane2_first_ready got %b want 1", obs_ready);
        end
        n_cmp++;
        if (data_out_valid !== 5'b00100 || data_out[2] !== 5'h15) begin
            n_fail++;
            $display("FAIL lane2_fill valid=%b data=%h want 00100/15", data_out_valid, data_out[2]);
        end
        do_cycle(0, 5'b00100, 5'h0A, 1, 5'b00000);
        n_cmp++;
        if (obs_ready !== 1'b0 || data_out[2] !== 5'h15) begin
            n_fail++;
            $display("FAIL lane2_blocked ready=%b data=%h want 0/15", obs_ready, data_out[2]);
        end
        do_cycle(0, 5'b00100, 5'h0A, 1, 5'b00100);
        n_cmp++;
        if (obs_ready !== 1'b1 || data_out_valid !== 5'b00100 || data_out[2] !== 5'h0A) begin
            n_fail++;
            $display("FAIL lane2_refill ready=%b valid=%b data=%h want 1/00100/0a",
                     obs_ready, data_out_valid, data_out[2]);
        end
        do_cycle(0, 5'b00000, 5'h00, 0, 5'b11111);
        n_cmp++;
        if (data_out_valid !== 5'b00000 || data_out[2] !== 5'h0A) begin
            n_fail++;
            $display("FAIL lane2_drain valid=%b data=%h want 00000/0a", data_out_valid, data_out[2]);
        end
    endtask

    task automatic test_stream();
        for (int k = 1; k <= 8; k++) begin
            do_cycle(0, 5'b00001, DW'(k), 1, 5'b00001);
            n_cmp++;
            if (obs_ready !== 1'b1 || data_out_valid !== 5'b00001 || data_out[0] !== DW'(k)) begin
                n_fail++;
                $display("FAIL stream word%0d ready=%b valid=%b data=%h", k,
                         obs_ready, data_out_valid, data_out[0]);
            end
        end
        do_cycle(0, 5'b00000, 5'h00, 0, 5'b00001);
        n_cmp++;
        if (data_out_valid !== 5'b00000) begin
            n_fail++; $display("FAIL stream_end valid=%b want 00000", data_out_valid);
        end
    endtask

    task automatic test_illegal();
        logic [SW-1:0] bad [2];
        bad[0] = 5'b00000;
        bad[1] = 5'b01010;
        for (int k = 0; k < 2; k++) begin
            do_cycle(0, bad[k], 5'h1F, 1, 5'b00000);
            n_cmp++;
            if (obs_ready !== 1'b1 || sel_error !== 1'b1 || drop_count !== 8'(k + 1)
                || data_out_valid !== 5'b00000) begin
                n_fail++;
                $display("FAIL illegal%0d ready=%b err=%b drops=%0d valid=%b want 1/1/%0d/00000",
                         k, obs_ready, sel_error, drop_count, data_out_valid, k + 1);
            end
        end
        do_cycle(0, 5'b00000, 5'h00, 0, 5'b00000);
        n_cmp++;
        if (sel_error !== 1'b0 || drop_count !== 8'd2) begin
            n_fail++;
            $display("FAIL illegal_idle err=%b drops=%0d want 0/2", sel_error, drop_count);
        end
        for (int k = 0; k < 300; k++) do_cycle(0, 5'b11000, 5'h03, 1, 5'b00000);
        n_cmp++;
        if (drop_count !== 8'd255 || sel_error !== 1'b1) begin
            n_fail++;
            $display("FAIL drop_saturate drops=%0d err=%b want 255/1", drop_count, sel_error);
        end
    endtask

    task automatic test_flush();
        do_cycle(0, 5'b00010, 5'h03, 1, 5'b00000);
        do_cycle(0, 5'b01000, 5'h09, 1, 5'b00000);
        n_cmp++;
        if (data_out_valid !== 5'b01010) begin
            n_fail++; $display("FAIL flush_setup valid=%b want 01010", data_out_valid);
        end
        do_cycle(1, 5'b00010, 5'h07, 1, 5'b00010);
        n_cmp++;
        if (obs_ready !== 1'b0 || data_out_valid !== 5'b00000 || sel_error !== 1'b0
            || data_out[1] !== 5'h03 || data_out[3] !== 5'h09 || drop_count !== 8'd255) begin
            n_fail++;
            $display("FAIL flush ready=%b valid=%b err=%b d1=%h d3=%h drops=%0d",
                     obs_ready, data_out_valid, sel_error, data_out[1], data_out[3], drop_count);
        end
        do_cycle(1, 5'b00000, 5'h07, 1, 5'b00000);
        n_cmp++;
        if (obs_ready !== 1'b0 || sel_error !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_illegal ready=%b err=%b want 0/0", obs_ready, sel_error);
        end
    endtask

    task automatic test_async_reset();
        do_cycle(0, 5'b00001, 5'h11, 1, 5'b00000);
        do_cycle(0, 5'b10000, 5'h1C, 1, 5'b00000);
        n_cmp++;
        if (data_out_valid !== 5'b10001) begin
            n_fail++; $display("FAIL areset_setup valid=%b want 10001", data_out_valid);
        end
        data_in_valid = 1'b0; flush = 1'b0;
        #2 rst = 1'b1;
        #1;
        m_reset();
        n_cmp++;
        if (data_out_valid !== 5'b00000 || data_out[0] !== '0 || data_out[4] !== '0
            || drop_count !== 8'd0 || data_in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL areset valid=%b d0=%h d4=%h drops=%0d ready=%b want 0/0/0/0/1",
                     data_out_valid, data_out[0], data_out[4], drop_count, data_in_ready);
        end
        #2 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [SW-1:0] s;
        logic [SW-1:0] r;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 7) == 0) s = SW'($urandom);
            else s = SW'(1) << $urandom_range(0, SW - 1);
            r = SW'($urandom);
            do_cycle($urandom_range(0, 15) == 0, s, DW'($urandom),
                     $urandom_range(0, 3) != 0, r);
            n_cmp++;
            if (obs_ready !== exp_ready) begin
                n_fail++;
                $display("FAIL rnd_ready cyc%0d got %b want %b", n, obs_ready, exp_ready);
            end
            n_cmp++;
            if (data_out_valid !== m_valid_vec() || sel_error !== m_sel_err
                || drop_count !== 8'(m_drops)) begin
                n_fail++;
                $display("FAIL rnd_ctrl cyc%0d valid=%b/%b err=%b/%b drops=%0d/%0d", n,
                         data_out_valid, m_valid_vec(), sel_error, m_sel_err, drop_count, m_drops);
            end
            for (int i = 0; i < SW; i++) begin
                n_cmp++;
                if (data_out[i] !== m_word[i]) begin
                    n_fail++;
                    $display("FAIL rnd_data cyc%0d lane%0d got %h want %h", n, i, data_out[i], m_word[i]);
                end
            end
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_single_lane();
        test_stream();
        test_illegal();
        test_flush();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
